ifetch_unit: RTL and testbench

//  Instruction-fetch stage; sits directly upstream of the decode stage. Holds the PC,

---
 rtl/ifetch_unit_if.sv | 12 +
 rtl/ifetch_unit.sv | 121 ++++++++++++
 tb/tb_ifetch_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
// A request issues when imem_req && imem_ack; words return in issue order on imem_rvalid.
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rvalid, imem_rdata);
endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: holds the PC, issues credit-limited in-order fetches, buffers
// returned words and presents {pco, insto} to decode; redirects discard stale replies.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] PC_STEP  = 32'd1,
    parameter int          FB_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    ifetch_unit_if.master imem,
    output logic [31:0]   pco,
    output logic [31:0]   insto,
    output logic          valid_o
);
    localparam int PW = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = CW + 2;

    logic [31:0]   fetch_pc;
    logic [31:0]   pend_pc  [FB_DEPTH];
    logic [31:0]   buf_pc   [FB_DEPTH];
    logic [31:0]   buf_inst [FB_DEPTH];
    logic [PW-1:0] pend_rd, pend_wr, buf_rd, buf_wr;
    logic [CW-1:0] pend_cnt, drop_cnt, buf_cnt;
    logic [SW-1:0] in_use;
    logic          issue, rsp_drop, rsp_acc, rsp_any, load, buf_pop, buf_push;
    logic [31:0]   rsp_pc;

    // Credit covers every request still owed a reply (including ones to be dropped) plus buffered words.
    assign in_use         = SW'(pend_cnt) + SW'(drop_cnt) + SW'(buf_cnt);
    assign imem.imem_req  = rst_n && !redirect && (in_use < SW'(FB_DEPTH));
    assign imem.imem_addr = fetch_pc;

    assign issue    = imem.imem_req && imem.imem_ack;
    assign rsp_drop = imem.imem_rvalid && (drop_cnt != '0);
    assign rsp_acc  = imem.imem_rvalid && (drop_cnt == '0) && (pend_cnt != '0);
    assign rsp_any  = rsp_drop || rsp_acc;
    assign rsp_pc   = pend_pc[pend_rd];
    assign load     = !valid_o || !stall;
    assign buf_pop  = load && (buf_cnt != '0);
    assign buf_push = rsp_acc && !(load && (buf_cnt == '0));

    // Queue storage needs no reset: the pointers and counts alone define what is valid.
    always_ff @(posedge clk) begin
        if (issue) begin
            pend_pc[pend_wr] <= fetch_pc;
        end
        if (buf_push) begin
            buf_pc[buf_wr]   <= rsp_pc;
            buf_inst[buf_wr] <= imem.imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            pend_rd  <= '0;
            pend_wr  <= '0;
            pend_cnt <= '0;
            drop_cnt <= '0;
            buf_rd   <= '0;
            buf_wr   <= '0;
            buf_cnt  <= '0;
            valid_o  <= 1'b0;
            pco      <= 32'h0;
            insto    <= 32'h0;
        end else if (redirect) begin
            // Replies still owed become drops; one arriving this cycle is itself discarded.
            fetch_pc <= redirect_pc;
            pend_rd  <= '0;
            pend_wr  <= '0;
            pend_cnt <= '0;
            drop_cnt <= pend_cnt + drop_cnt - CW'(rsp_any);
            buf_rd   <= '0;
            buf_wr   <= '0;
            buf_cnt  <= '0;
            valid_o  <= 1'b0;
            insto    <= 32'h0;
        end else begin
            if (issue) begin
                pend_wr  <= pend_wr + PW'(1);
                fetch_pc <= fetch_pc + PC_STEP;
            end
            if (rsp_acc) begin
                pend_rd <= pend_rd + PW'(1);
            end
            pend_cnt <= pend_cnt + CW'(issue) - CW'(rsp_acc);
            drop_cnt <= drop_cnt - CW'(rsp_drop);
            if (buf_push) begin
                buf_wr <= buf_wr + PW'(1);
            end
            if (buf_pop) begin
                buf_rd <= buf_rd + PW'(1);
            end
            buf_cnt <= buf_cnt + CW'(buf_push) - CW'(buf_pop);
            // Buffered words go first so a bypassed reply can never overtake older ones.
            if (load) begin
                if (buf_cnt != '0) begin
                    pco     <= buf_pc[buf_rd];
                    insto   <= buf_inst[buf_rd];
                    valid_o <= 1'b1;
                end else if (rsp_acc) begin
                    pco     <= rsp_pc;
                    insto   <= imem.imem_rdata;
                    valid_o <= 1'b1;
                end else begin
                    insto   <= 32'h0;
                    valid_o <= 1'b0;
                end
            end
        end
    end

    // Memory must never answer a request that was never issued.
    assert property (@(posedge clk) disable iff (!rst_n)
        imem.imem_rvalid |-> (pend_cnt != '0 || drop_cnt != '0));

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: an in-order imem model with random ack/latency drives the DUT while
// a queue-based reference model of the fetch rules predicts the bus and decode-side outputs.
module tb_ifetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] PC_STEP  = 32'd1;
    localparam int          FB_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pco;
    logic [31:0] insto;
    logic        valid_o;

    ifetch_unit_if bus ();

    ifetch_unit #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP), .FB_DEPTH(FB_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem(bus), .pco(pco), .insto(insto), .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [31:0] pc; bit drop; } owed_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } word_t;
    typedef struct { logic [31:0] data; int ready; } rsp_t;

    owed_t       m_owed[$];
    word_t       m_buf[$];
    logic [31:0] m_fetch_pc, m_pco, m_insto;
    logic        m_valid;
    rsp_t        mem_q[$];
    int          cyc = 0;
    int          last_ready = 0;
    int          ack_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    logic        exp_req, smp_req;
    logic [31:0] exp_addr, smp_addr;

    task automatic model_reset();
        m_owed.delete();
        m_buf.delete();
        mem_q.delete();
        m_fetch_pc = RESET_PC;
        m_pco      = 32'h0;
        m_insto    = 32'h0;
        m_valid    = 1'b0;
        last_ready = 0;
    endtask

    // One clock cycle: memory answers, bus is sampled before the edge, model advances at the edge.
    task automatic tick();
        bit          rv, ack, have_acc;
        logic [31:0] rdat;
        word_t       acc;
        owed_t       o;
        rsp_t        r;
        int          lat;
        ack  = ($urandom_range(0, 99) < ack_pct);
        rv   = (mem_q.size() > 0) && (mem_q[0].ready <= cyc);
        rdat = rv ? mem_q[0].data : $urandom();
        bus.imem_ack    = ack;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rdat;
        #1;
        exp_req  = rst_n && !redirect && ((m_owed.size() + m_buf.size()) < FB_DEPTH);
        exp_addr = m_fetch_pc;
        smp_req  = bus.imem_req;
        smp_addr = bus.imem_addr;
        @(posedge clk);
        if (rv) void'(mem_q.pop_front());
        if (smp_req && ack) begin
            lat     = $urandom_range(lat_min, lat_max);
            r.ready = (cyc + lat > last_ready) ? cyc + lat : last_ready + 1;
            r.data  = smp_addr + 32'hA000;
            last_ready = r.ready;
            mem_q.push_back(r);
        end
        have_acc = 1'b0;
        if (rv && m_owed.size() > 0) begin
            o = m_owed.pop_front();
            if (!o.drop) begin
                acc.pc   = o.pc;
                acc.inst = rdat;
                have_acc = 1'b1;
            end
        end
        if (redirect) begin
            foreach (m_owed[i]) m_owed[i].drop = 1'b1;
            m_buf.delete();
            m_fetch_pc = redirect_pc;
            m_valid    = 1'b0;
            m_insto    = 32'h0;
        end else begin
            if (exp_req && ack) begin
                o.pc   = m_fetch_pc;
                o.drop = 1'b0;
                m_owed.push_back(o);
                m_fetch_pc = m_fetch_pc + PC_STEP;
            end
            if (have_acc) m_buf.push_back(acc);
            if (!m_valid || !stall) begin
                if (m_buf.size() > 0) begin
                    acc     = m_buf.pop_front();
                    m_pco   = acc.pc;
                    m_insto = acc.inst;
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                    m_insto = 32'h0;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        bus.imem_ack = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({valid_o, pco, insto} !== 65'h0) begin
            errors++;
            $display("[TB] FAIL reset_out got v=%0b pc=%h i=%h exp all zero", valid_o, pco, insto);
        end
        checks++;
        if (bus.imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_req got %0b exp 0", bus.imem_req);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, RESET_PC}) begin
            errors++;
            $display("[TB] FAIL release_req got req=%0b addr=%h exp req=1 addr=%h", bus.imem_req, bus.imem_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        ack_pct = 100; lat_min = 1; lat_max = 1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if ({smp_req, smp_addr} !== {exp_req, exp_addr}) begin
                errors++;
                $display("[TB] FAIL stream_bus cyc=%0d got req=%0b addr=%h exp req=%0b addr=%h", cyc, smp_req, smp_addr, exp_req, exp_addr);
            end
            checks++;
            if (k == 0 ? (valid_o !== 1'b0) : ({valid_o, pco, insto} !== {1'b1, 32'(k - 1), 32'(k - 1) + 32'hA000})) begin
                errors++;
                $display("[TB] FAIL stream_out k=%0d got v=%0b pc=%h i=%h exp pc=%h", k, valid_o, pco, insto, 32'(k - 1));
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] frozen;
        frozen = m_pco;
        stall  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({smp_req, smp_addr} !== {exp_req, exp_addr} || (k == 2 && smp_req !== 1'b0)) begin
                errors++;
                $display("[TB] FAIL stall_bus k=%0d got req=%0b addr=%h exp req=%0b addr=%h", k, smp_req, smp_addr, exp_req, exp_addr);
            end
            checks++;
            if ({valid_o, pco, insto} !== {1'b1, frozen, frozen + 32'hA000}) begin
                errors++;
                $display("[TB] FAIL stall_hold k=%0d got v=%0b pc=%h i=%h exp pc=%h", k, valid_o, pco, insto, frozen);
            end
        end
        stall = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if ({valid_o, pco, insto} !== {1'b1, frozen + 32'(k), frozen + 32'(k) + 32'hA000}) begin
                errors++;
                $display("[TB] FAIL stall_resume k=%0d got v=%0b pc=%h i=%h exp pc=%h", k, valid_o, pco, insto, frozen + 32'(k));
            end
        end
    endtask

    task automatic test_redirect();
        int n;
        lat_min = 2; lat_max = 2;
        repeat (4) tick();
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0; lat_min = 1; lat_max = 1;
        checks++;
        if ({valid_o, insto} !== 33'h0) begin
            errors++;
            $display("[TB] FAIL redirect_bubble got v=%0b i=%h exp v=0 i=0", valid_o, insto);
        end
        for (int target = 'h40; target <= 'h41; target++) begin
            n = 0;
            do begin
                tick();
                n++;
                checks++;
                if ({valid_o, pco, insto} !== {m_valid, m_pco, m_insto}) begin
                    errors++;
                    $display("[TB] FAIL redirect_model cyc=%0d got v=%0b pc=%h i=%h exp v=%0b pc=%h i=%h", cyc, valid_o, pco, insto, m_valid, m_pco, m_insto);
                end
            end while (!valid_o && n < 20);
            checks++;
            if ({valid_o, pco, insto} !== {1'b1, 32'(target), 32'(target) + 32'hA000}) begin
                errors++;
                $display("[TB] FAIL redirect_target got v=%0b pc=%h i=%h exp pc=%h", valid_o, pco, insto, 32'(target));
            end
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] wait_addr;
        repeat (3) tick();
        ack_pct   = 0;
        wait_addr = m_fetch_pc;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({smp_req, smp_addr} !== {1'b1, wait_addr}) begin
                errors++;
                $display("[TB] FAIL wait_addr k=%0d got req=%0b addr=%h exp req=1 addr=%h", k, smp_req, smp_addr, wait_addr);
            end
            checks++;
            if ((k >= 1) && ({valid_o, insto} !== 33'h0)) begin
                errors++;
                $display("[TB] FAIL wait_bubble k=%0d got v=%0b i=%h exp v=0 i=0", k, valid_o, insto);
            end
        end
        ack_pct = 100;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if ({valid_o, pco, insto} !== {m_valid, m_pco, m_insto} || (k == 1 && pco !== wait_addr)) begin
                errors++;
                $display("[TB] FAIL wait_resume k=%0d got v=%0b pc=%h i=%h exp v=%0b pc=%h i=%h", k, valid_o, pco, insto, m_valid, m_pco, m_insto);
            end
        end
    endtask

    task automatic test_redirect_stall();
        int n;
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
        tick();
        redirect = 1'b0;
        checks++;
        if ({valid_o, insto} !== 33'h0) begin
            errors++;
            $display("[TB] FAIL redir_stall_out got v=%0b i=%h exp v=0 i=0", valid_o, insto);
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (!valid_o && n < 20);
        checks++;
        if ({valid_o, pco} !== {1'b1, 32'h80}) begin
            errors++;
            $display("[TB] FAIL redir_stall_target got v=%0b pc=%h exp v=1 pc=00000080", valid_o, pco);
        end
        stall = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_random();
        ack_pct = 70; lat_min = 1; lat_max = 4;
        for (int k = 0; k < 400; k++) begin
            stall       = ($urandom_range(0, 99) < 30);
            redirect    = ($urandom_range(0, 99) < 4);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom();
            tick();
            checks++;
            if ({smp_req, smp_addr} !== {exp_req, exp_addr}) begin
                errors++;
                $display("[TB] FAIL random_bus cyc=%0d got req=%0b addr=%h exp req=%0b addr=%h", cyc, smp_req, smp_addr, exp_req, exp_addr);
            end
            checks++;
            if ({valid_o, pco, insto} !== {m_valid, m_pco, m_insto}) begin
                errors++;
                $display("[TB] FAIL random_out cyc=%0d got v=%0b pc=%h i=%h exp v=%0b pc=%h i=%h", cyc, valid_o, pco, insto, m_valid, m_pco, m_insto);
            end
        end
        stall = 1'b0; redirect = 1'b0;
        ack_pct = 100; lat_min = 1; lat_max = 1;
    endtask

    task automatic test_async_reset();
        int n;
        repeat (6) tick();
        #2;
        rst_n = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_rvalid = 1'b0;
        #1;
        checks++;
        if ({valid_o, pco, insto, bus.imem_req} !== 66'h0) begin
            errors++;
            $display("[TB] FAIL async_reset got v=%0b pc=%h i=%h req=%0b exp all zero", valid_o, pco, insto, bus.imem_req);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            checks++;
            if ({smp_req, smp_addr, valid_o, pco, insto} !== {exp_req, exp_addr, m_valid, m_pco, m_insto}) begin
                errors++;
                $display("[TB] FAIL restart_model cyc=%0d got req=%0b v=%0b pc=%h exp req=%0b v=%0b pc=%h", cyc, smp_req, valid_o, pco, exp_req, m_valid, m_pco);
            end
        end while (!valid_o && n < 10);
        checks++;
        if ({valid_o, pco, insto} !== {1'b1, RESET_PC, RESET_PC + 32'hA000}) begin
            errors++;
            $display("[TB] FAIL restart_pc got v=%0b pc=%h i=%h exp pc=%h", valid_o, pco, insto, RESET_PC);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wait_states();
        test_redirect_stall();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
